// File: rtl/dense_frame_collector.sv
// Serial-to-parallel frame collector: assembles N_WORDS signed words into one held vector.
// Optional running argmax of the frame is enabled with DENSE_COLLECT_ARGMAX_EN.
module dense_frame_collector #(
  parameter int N_WORDS    = 120,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_start_in,
  input  logic                                  frame_end_in,
  input  logic                                  valid_in,
  input  logic signed [DATA_WIDTH-1:0]          data_in,
  input  logic                                  vec_ready,
  output logic                                  vec_valid,
  output logic        [N_WORDS*DATA_WIDTH-1:0]  vec_data,
  output logic                                  frame_err,
  output logic                                  overrun,
  output logic        [9:0]                     max_idx
);

  localparam int CW = 11;
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         vec_valid_q, vec_valid_d;
  logic                         frame_err_q, frame_err_d;
  logic                         overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0] buf_q [N_WORDS];
  logic signed [DATA_WIDTH-1:0] buf_d [N_WORDS];
  logic                         wr_en;
  logic [CW-1:0]                wr_idx;
  logic                         do_start;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    vec_valid_d = vec_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    do_start    = 1'b0;

    case (state_q)
      IDLE: begin
        do_start = valid_in & frame_start_in;
      end
      COLLECT: begin
        if (valid_in) begin
          if (frame_start_in) begin
            frame_err_d = 1'b1;
            do_start    = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = count_q;
            count_d = count_q + CW'(1);
            if (frame_end_in) begin
              count_d = '0;
              if (count_q == LAST) begin
                state_d     = HOLD;
                vec_valid_d = 1'b1;
              end else begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
              end
            end else if (count_q >= LAST) begin
              // Last slot already filled and still no end marker: frame too long.
              frame_err_d = 1'b1;
              state_d     = IDLE;
              count_d     = '0;
            end
          end
        end
      end
      HOLD: begin
        if (vec_ready) begin
          vec_valid_d = 1'b0;
          state_d     = IDLE;
          count_d     = '0;
          do_start    = valid_in & frame_start_in;
        end else if (valid_in) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new frame start (from IDLE, mid-frame restart, or the handshake cycle).
    if (do_start) begin
      wr_en   = 1'b1;
      wr_idx  = '0;
      count_d = CW'(1);
      if (frame_end_in) begin
        count_d = '0;
        if (N_WORDS == 1) begin
          state_d     = HOLD;
          vec_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end else begin
        state_d = COLLECT;
      end
    end
  end

  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < N_WORDS; i++) begin
      if (wr_en && wr_idx == CW'(i)) buf_d[i] = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      vec_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      vec_valid_q <= vec_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      buf_q       <= buf_d;
    end
  end

  for (genvar g = 0; g < N_WORDS; g++) begin : g_vec
    assign vec_data[g*DATA_WIDTH +: DATA_WIDTH] = buf_q[g];
  end

  assign vec_valid = vec_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef DENSE_COLLECT_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic [9:0]                   max_idx_q, max_idx_d;

  // Word 0 seeds the search; strict greater-than keeps the lower index on ties.
  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (wr_en) begin
      if (wr_idx == '0) begin
        max_val_d = data_in;
        max_idx_d = '0;
      end else if (data_in > max_val_q) begin
        max_val_d = data_in;
        max_idx_d = wr_idx[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign max_idx = max_idx_q;
`else
  assign max_idx = '0;
`endif

endmodule

// File: tb/tb_dense_frame_collector.sv
// Directed-vector bench for dense_frame_collector (N_WORDS=120, DATA_WIDTH=16).
module tb_dense_frame_collector;

  localparam int N  = 120;
  localparam int DW = 16;
`ifdef DENSE_COLLECT_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_start_in;
  logic                 frame_end_in;
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic                 vec_ready;
  logic                 vec_valid;
  logic [N*DW-1:0]      vec_data;
  logic                 frame_err;
  logic                 overrun;
  logic [9:0]           max_idx;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int base;
  logic [DW-1:0] exp_mem [N];

  dense_frame_collector #(.N_WORDS(N), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start_in (frame_start_in),
    .frame_end_in   (frame_end_in),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .vec_ready      (vec_ready),
    .vec_valid      (vec_valid),
    .vec_data       (vec_data),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .max_idx        (max_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag);
    for (int k = 0; k < N; k++) chk(tag, 32'(vec_data[k*DW +: DW]), 32'(exp_mem[k]));
  endtask

  function automatic logic [9:0] exp_max(input int m);
    return ARGMAX ? 10'(m) : 10'd0;
  endfunction

  task automatic drive(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    valid_in = v; frame_start_in = s; frame_end_in = e; data_in = d;
    @(posedge clk); #1;
    valid_in = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; frame_start_in = 1'b0; frame_end_in = 1'b0;
    data_in = '0; vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec_valid", 32'(vec_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun",   32'(overrun), 0);
    chk("rst_max_idx",   32'(max_idx), 0);
    chk("rst_data_zero", 32'(|vec_data), 0);
    rst = 1'b0;

    // Full frame, values i-60, downstream always ready
    vec_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, i == 0, i == N-1, DW'(i - 60));
      if (i == N-2) chk("a_not_early", 32'(vec_valid), 0);
    end
    chk("a_vec_valid", 32'(vec_valid), 1);
    for (int k = 0; k < N; k++) exp_mem[k] = DW'(k - 60);
    check_vec("a_word");
    chk("a_max_idx", 32'(max_idx), 32'(exp_max(119)));
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("a_pulse_end", 32'(vec_valid), 0);

    // Short frame: end marker on word 50
    base = err_cnt;
    for (int i = 0; i <= 50; i++) drive(1'b1, i == 0, i == 50, DW'(1000 + i));
    chk("b_frame_err", 32'(frame_err), 1);
    chk("b_vec_valid", 32'(vec_valid), 0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("b_err_pulse", 32'(frame_err), 0);
    chk("b_err_count", 32'(err_cnt - base), 1);
    chk("b_no_vec", 32'(vec_valid), 0);

    // Restart at word 30, then a full second frame held (ready low)
    vec_ready = 1'b0;
    base = err_cnt;
    for (int i = 0; i < 30; i++) drive(1'b1, i == 0, 1'b0, DW'(500 + i));
    for (int j = 0; j < N; j++) begin
      drive(1'b1, j == 0, j == N-1, DW'(2000 + j));
      if (j == 0) chk("c_restart_err", 32'(frame_err), 1);
    end
    chk("c_vec_valid", 32'(vec_valid), 1);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("c_err_count", 32'(err_cnt - base), 1);
    for (int k = 0; k < N; k++) exp_mem[k] = DW'(2000 + k);
    check_vec("c_word");
    chk("c_max_idx", 32'(max_idx), 32'(exp_max(119)));

    // Held vector with three stray words injected
    for (int c = 0; c < 10; c++) drive(c == 2 || c == 5 || c == 7, 1'b0, 1'b0, 16'h1234);
    chk("d_still_valid", 32'(vec_valid), 1);
    check_vec("d_word_stable");
    chk("d_overrun", 32'(overrun), 1);
    vec_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("d_released", 32'(vec_valid), 0);
    chk("d_overrun_sticky", 32'(overrun), 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    chk("d_overrun_rst", 32'(overrun), 0);

    // Back-to-back frames, second start on the handshake cycle
    base = err_cnt;
    for (int i = 0; i < 2*N; i++) begin
      drive(1'b1, (i % N) == 0, (i % N) == N-1, (i < N) ? DW'(3 * i) : DW'(-(i - N)));
      if (i == N-1) begin
        chk("e_first_valid", 32'(vec_valid), 1);
        for (int k = 0; k < N; k++) exp_mem[k] = DW'(3 * k);
        check_vec("e_first_word");
        chk("e_first_max", 32'(max_idx), 32'(exp_max(119)));
      end
      if (i == N) chk("e_handshake", 32'(vec_valid), 0);
    end
    chk("e_second_valid", 32'(vec_valid), 1);
    for (int k = 0; k < N; k++) exp_mem[k] = DW'(-k);
    check_vec("e_second_word");
    chk("e_second_max", 32'(max_idx), 32'(exp_max(0)));
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("e_no_err", 32'(err_cnt - base), 0);
    chk("e_no_overrun", 32'(overrun), 0);

    // Reset at word 60, orphan words, then a clean frame
    vec_ready = 1'b0;
    for (int i = 0; i < 60; i++) drive(1'b1, i == 0, 1'b0, DW'(99));
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, DW'(99));
    rst = 1'b0;
    chk("f_rst_valid", 32'(vec_valid), 0);
    chk("f_rst_data", 32'(|vec_data), 0);
    base = err_cnt;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'(5));
    drive(1'b1, 1'b0, 1'b1, DW'(5));
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("f_orphan_valid", 32'(vec_valid), 0);
    chk("f_orphan_err", 32'(err_cnt - base), 0);
    chk("f_orphan_data", 32'(|vec_data), 0);
    for (int i = 0; i < N; i++) drive(1'b1, i == 0, i == N-1, (i == 5) ? 16'h7FFF : DW'(7));
    chk("f_vec_valid", 32'(vec_valid), 1);
    for (int k = 0; k < N; k++) exp_mem[k] = (k == 5) ? 16'h7FFF : DW'(7);
    check_vec("f_word");
    chk("f_max_idx", 32'(max_idx), 32'(exp_max(5)));
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("f_hold", 32'(vec_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
